// File: rtl/fp_accum_ctrl_if.sv
// Bundle of handshake and datapath signals between fp_accum_ctrl and its environment.
// slave  : the controller side (drives busy, in_ready, add_a/add_b, out_valid/out_data).
// master : the environment side (drives start/len, input stream, add_result, out_ready).
interface fp_accum_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_result;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;

    modport slave (
        input  start, len, in_valid, in_data, add_result, out_ready,
        output busy, in_ready, add_a, add_b, out_valid, out_data
    );

    modport master (
        output start, len, in_valid, in_data, add_result, out_ready,
        input  busy, in_ready, add_a, add_b, out_valid, out_data
    );
endinterface

// File: rtl/fp_accum_ctrl.sv
// Reduces a stream of len IEEE-754 singles into one sum by sequencing a shared external FP adder.
// Latency: 1 cycle/element on zero/cancel bypass, ADDER_LAT+1 cycles/element through the adder.
// Backpressure: in_ready low outside LOAD/FETCH; result held in DONE until out_ready.
// Ports: clk/rst (sync active-high), bus (slave modport): start/len/busy job control,
// in_valid/in_data/in_ready element stream, add_a/add_b/add_result adder link,
// out_valid/out_data/out_ready result.
module fp_accum_ctrl #(
    parameter int ADDER_LAT = 1,
    parameter int LEN_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    fp_accum_ctrl_if.slave      bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int WAIT_W = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ADDER_LAT - 1);

    logic [2:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  remaining;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       acc;
    logic [31:0]       opnd;

    logic in_zero;
    logic acc_zero;
    logic cancel;
    logic needs_add;

    // Exponent field zero means zero; denormals are flushed and the sign is ignored.
    assign in_zero   = (bus.in_data[30:23] == 8'd0);
    assign acc_zero  = (acc[30:23] == 8'd0);
    // Equal magnitude, opposite sign: the adder cannot produce zero, so resolve here.
    assign cancel    = (acc[30:0] == bus.in_data[30:0]) && (acc[31] != bus.in_data[31]);
    assign needs_add = !in_zero && !acc_zero && !cancel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            acc       <= 32'd0;
            opnd      <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q     <= bus.len;
                        remaining <= '0;
                        if (bus.len == '0) begin
                            acc   <= 32'd0;
                            state <= S_DONE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (bus.in_valid) begin
                        acc       <= in_zero ? 32'd0 : bus.in_data;
                        remaining <= len_q - LEN_W'(1);
                        state     <= (len_q == LEN_W'(1)) ? S_DONE : S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (bus.in_valid) begin
                        remaining <= remaining - LEN_W'(1);
                        if (!in_zero) begin
                            if (acc_zero) begin
                                acc <= bus.in_data;
                            end else if (cancel) begin
                                acc <= 32'd0;
                            end else begin
                                opnd     <= bus.in_data;
                                wait_cnt <= WAIT_INIT;
                            end
                        end
                        // remaining still holds the pre-decrement count here.
                        if (needs_add) begin
                            state <= S_ADD;
                        end else if (remaining == LEN_W'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end

                S_ADD: begin
                    if (wait_cnt == '0) begin
                        acc   <= bus.add_result;
                        state <= (remaining == '0) ? S_DONE : S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Operands come straight from the acc/opnd flops, so they stay glitch-free
    // and stable for the whole ADD window.
    assign bus.add_a     = acc;
    assign bus.add_b     = opnd;
    assign bus.busy      = (state != S_IDLE);
    assign bus.in_ready  = (state == S_LOAD) || (state == S_FETCH);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_data  = acc;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
module tb_fp_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_accum_ctrl_if #(.LEN_W(8)) if1 ();
    fp_accum_ctrl_if #(.LEN_W(8)) if3 ();

    // Truncating FP adder as the shared unit would behave: implicit leading one always,
    // smaller operand aligned by right shift with dropped bits, result truncated.
    function automatic logic [31:0] fadd(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b;
        logic [25:0] ma, mb, m;
        logic [7:0]  e;
        int          sh;
        a = a_in;
        b = b_in;
        if (a[30:0] < b[30:0]) begin
            a = b_in;
            b = a_in;
        end
        ma = {3'b001, a[22:0]};
        mb = {3'b001, b[22:0]};
        sh = int'(a[30:23]) - int'(b[30:23]);
        mb = (sh > 25) ? 26'd0 : (mb >> sh);
        m  = (a[31] == b[31]) ? (ma + mb) : (ma - mb);
        e  = a[30:23];
        if (m[24]) begin
            m = m >> 1;
            e = e + 8'd1;
        end else begin
            for (int i = 0; i < 24 && !m[23]; i++) begin
                m = m << 1;
                e = e - 8'd1;
            end
        end
        return {a[31], e, m[22:0]};
    endfunction

    function automatic bit is_zero(input logic [31:0] x);
        return x[30:23] == 8'd0;
    endfunction

    // Environment: only the selected controller sees start/in_valid/out_ready.
    assign if1.start     = start & ~sel;
    assign if3.start     = start & sel;
    assign if1.len       = len;
    assign if3.len       = len;
    assign if1.in_valid  = in_valid & ~sel;
    assign if3.in_valid  = in_valid & sel;
    assign if1.in_data   = in_data;
    assign if3.in_data   = in_data;
    assign if1.out_ready = out_ready & ~sel;
    assign if3.out_ready = out_ready & sel;

    // Latency-1 adder: combinational. Latency-3 adder: two pipeline registers behind it.
    assign if1.add_result = fadd(if1.add_a, if1.add_b);
    logic [31:0] pipe1, pipe2;
    always @(posedge clk) begin
        pipe1 <= fadd(if3.add_a, if3.add_b);
        pipe2 <= pipe1;
    end
    assign if3.add_result = pipe2;

    fp_accum_ctrl #(.ADDER_LAT(1), .LEN_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    fp_accum_ctrl #(.ADDER_LAT(3), .LEN_W(8)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic        busy_m, in_ready_m, out_valid_m;
    logic [31:0] out_data_m, add_a_m, add_b_m;
    assign busy_m      = sel ? if3.busy      : if1.busy;
    assign in_ready_m  = sel ? if3.in_ready  : if1.in_ready;
    assign out_valid_m = sel ? if3.out_valid : if1.out_valid;
    assign out_data_m  = sel ? if3.out_data  : if1.out_data;
    assign add_a_m     = sel ? if3.add_a     : if1.add_a;
    assign add_b_m     = sel ? if3.add_b     : if1.add_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        chkb({tag, "_busy"},      busy_m,      1'b0);
        chkb({tag, "_in_ready"},  in_ready_m,  1'b0);
        chkb({tag, "_out_valid"}, out_valid_m, 1'b0);
        chk ({tag, "_out_data"},  out_data_m,  32'd0);
        chk ({tag, "_add_a"},     add_a_m,     32'd0);
        chk ({tag, "_add_b"},     add_b_m,     32'd0);
    endtask

    logic [31:0] elems[$];
    logic [31:0] pool [0:9] = '{32'h00000000, 32'h00400000, 32'h3F800000, 32'h40000000,
                                32'h3F000000, 32'h40400000, 32'h3FC00000, 32'h3E800000,
                                32'h40800000, 32'h3F800000};

    function automatic logic [31:0] pick();
        logic [31:0] v;
        v = pool[$urandom_range(0, 9)];
        if ($urandom_range(0, 1) == 1) v[31] = ~v[31];
        return v;
    endfunction

    // One job on the selected controller. The expected sum and the exact cycle at which
    // each element is accepted follow from the per-element reduction rules.
    task automatic run_job(input bit s, input int n, input int gap_max, input int hold);
        int          lat;
        logic [31:0] m_acc, x;
        bit          use_add;
        lat = s ? 3 : 1;
        sel = s;
        start = 1'b1; len = n[7:0]; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        start = 1'b0;
        chkb("busy_after_start", busy_m, 1'b1);
        m_acc = 32'd0;
        for (int i = 0; i < n; i++) begin
            x = elems[i];
            for (int g = $urandom_range(gap_max, 0); g > 0; g--) begin
                in_valid = 1'b0;
                chkb("in_ready_gap", in_ready_m, 1'b1);
                tick();
            end
            in_valid = 1'b1;
            in_data  = x;
            chkb("in_ready_elem", in_ready_m, 1'b1);
            tick();
            use_add = 1'b0;
            if (i == 0)                            m_acc = is_zero(x) ? 32'd0 : x;
            else if (is_zero(x))                   m_acc = m_acc;
            else if (is_zero(m_acc))               m_acc = x;
            else if (x == (m_acc ^ 32'h80000000))  m_acc = 32'd0;
            else                                   use_add = 1'b1;
            if (use_add) begin
                for (int k = 0; k < lat; k++) begin
                    chkb("in_ready_add", in_ready_m, 1'b0);
                    chk ("add_a_hold", add_a_m, m_acc);
                    chk ("add_b_hold", add_b_m, x);
                    tick();
                end
                m_acc = fadd(m_acc, x);
            end
        end
        chkb("out_valid_done", out_valid_m, 1'b1);
        chk ("out_data_done",  out_data_m,  m_acc);
        chkb("in_ready_done",  in_ready_m,  1'b0);
        for (int h = 0; h < hold; h++) begin
            start    = ($urandom_range(0, 1) == 1);
            in_valid = ($urandom_range(0, 1) == 1);
            tick();
            chkb("out_valid_hold", out_valid_m, 1'b1);
            chk ("out_data_hold",  out_data_m,  m_acc);
            chkb("busy_hold",      busy_m,      1'b1);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        chkb("out_valid_after_hs", out_valid_m, 1'b0);
        chkb("busy_after_hs",      busy_m,      1'b0);
    endtask

    initial begin
        sel = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 32'd0;
        out_ready = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sel = 1'b0; check_idle_zero("reset_lat1");
        sel = 1'b1; check_idle_zero("reset_lat3");
        rst = 1'b0;
        tick();

        // 1.0 + 2.0 + 0.5 through the latency-1 adder
        elems = '{32'h3F800000, 32'h40000000, 32'h3F000000};
        run_job(1'b0, 3, 0, 0);
        // zero-length jobs on both controllers
        elems = {};
        run_job(1'b0, 0, 0, 1);
        run_job(1'b1, 0, 0, 0);
        // cancellation bypass, then a value into a zero accumulator
        elems = '{32'h3F800000, 32'hBF800000, 32'h40000000};
        run_job(1'b0, 3, 0, 0);
        // zeros of both signs skipped; only the last element goes through the adder
        elems = '{32'h00000000, 32'h40400000, 32'h80000000, 32'h3F800000};
        run_job(1'b0, 4, 0, 0);
        // latency-3 adder with a stalled consumer
        elems = '{32'h3F800000, 32'h3F800000};
        run_job(1'b1, 2, 0, 5);

        // reset in the middle of an ADD window aborts the job
        sel = 1'b1; start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 32'h3F800000;
        tick();
        in_data = 32'h3FC00000;
        tick();
        chkb("in_ready_before_rst", in_ready_m, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("mid_add_rst");
        tick();
        chkb("no_output_after_rst", out_valid_m, 1'b0);
        elems = '{32'h40400000};
        run_job(1'b1, 1, 0, 0);
        run_job(1'b0, 1, 0, 0);

        // random jobs on both controllers
        repeat (40) begin
            int n;
            n = $urandom_range(0, 10);
            elems = {};
            for (int i = 0; i < n; i++) elems.push_back(pick());
            run_job($urandom_range(0, 1) == 1, n, 2, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
